timer_multi_ch: RTL
===================

Name: timer_multi_ch

Overview:
Memory-mapped multi-channel up-counter/timer. Generalises the single 8-bit counter (control at 0x0, count at 0x4) to NUM_CH independent channels with parametrised width, a compare register, a free-run or auto-reload mode, sticky W1C status and per-channel interrupt lines. Sits on the same simple wr_en/rd_en/addr/wdata/rdata register bus as the existing peripherals.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
CNT_WIDTH, 16, counter and compare width in bits (1..32)
ADDR_WIDTH, 10, bus address width
DATA_WIDTH, 32, bus data width (>= CNT_WIDTH)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe, one write per cycle
rd_en  in  1  read strobe
addr  in  ADDR_WIDTH  byte address
wdata  in  DATA_WIDTH  write data
rdata  out  DATA_WIDTH  registered read data
overflow  out  NUM_CH  per-channel sticky overflow flag (STATUS.OVF)
irq  out  NUM_CH  per-channel interrupt = (OVF & CTRL.OVF_IE) | (MATCH & CTRL.MATCH_IE)

Behaviour:
- Map: channel n base = n*0x10; ch = addr>>4; ch >= NUM_CH is unmapped. addr[1:0] ignored.
- +0x0 CTRL RW: [0] EN, [1] CLR (write-only, self-clearing, reads 0), [2] MODE (0 free-run, 1 auto-reload), [3] OVF_IE, [4] MATCH_IE. Other bits read 0.
- +0x4 COUNT RO, zero-extended. Writes ignored.
- +0x8 COMPARE RW, CNT_WIDTH bits, zero-extended.
- +0xC STATUS: [0] OVF, [1] MATCH; write 1 clears, write 0 has no effect.
- Reset: all CTRL, COUNT, COMPARE, STATUS = 0; rdata = 0; overflow = 0; irq = 0.
- Read: on an edge with rd_en = 1, rdata <= selected register. Valid the cycle after the strobe; holds its value when rd_en = 0. Unmapped addresses return 0.
- Simultaneous wr_en and rd_en: both execute; read returns the pre-write value.
- Tick: every cycle while EN = 1 (see optional feature). EN = 0 freezes COUNT; flags are kept.
- On a tick:
  - MODE 0: COUNT+1; MAX (2^CNT_WIDTH-1) -> 0 and set OVF.
  - MODE 1: if COUNT == COMPARE then COUNT <= 0, else COUNT+1. Period is COMPARE+1 ticks. OVF is set only when wrapping from MAX.
  - Both modes: set MATCH on the tick where COUNT == COMPARE (leaving that value).
- CLR written: COUNT <= 0 on that edge. Overrides a same-cycle tick; no flag is set by that tick. The CTRL write of the other bits also takes effect that edge.
- Same-cycle hardware flag set and W1C: set wins.
- COMPARE written mid-count: new value applies from the next edge. If COUNT > COMPARE in MODE 1, the counter runs to MAX, wraps (OVF) and then matches normally.
- Async reset mid-count: everything returns to reset values immediately.
- irq and overflow are combinational from flops (no extra latency).

Optional Feature:
TIMER_PRESCALER_EN.
- Defined: CTRL[15:8] = PSC (RW). A per-channel 8-bit prescaler counter gives one tick every PSC+1 enabled cycles.
  - Prescaler counter resets to 0 on reset, on CLR, and while EN = 0.
  - A PSC write restarts the prescaler from 0.
- Undefined: CTRL[15:8] reads 0, writes are ignored, one tick per enabled cycle.

Decomposition:
- Package timer_pkg: register offsets (CTRL/COUNT/COMPARE/STATUS), CTRL and STATUS bit-index constants, MODE encodings, channel stride 0x10.
- Sub-module timer_channel:
  - Contains one channel's CTRL/COUNT/COMPARE/STATUS, tick and prescaler logic.
  - Ports: decoded write strobes per register, read mux output, ovf, irq.
- Top: address decode, generate loop over NUM_CH, registered read mux.

Test Plan:
- Reset, then read CTRL/COUNT/COMPARE/STATUS of all channels -> all 0; overflow = 0, irq = 0.
- ch0: COMPARE = 3, CTRL = 0x05 (EN, MODE 1). Sample COUNT each cycle -> 0,1,2,3,0,1...; MATCH set on the 3->0 tick; OVF stays 0.
- ch1, CNT_WIDTH = 16: CTRL = 0x09 (EN, OVF_IE), run 65536 ticks -> COUNT wraps to 0, overflow[1] = 1, irq[1] = 1. Write STATUS = 0x1 -> overflow[1] = 0, irq[1] = 0.
- ch2 running at COUNT = 0x20: write CTRL = 0x03 (EN + CLR) -> COUNT = 0 next cycle, counting resumes, CTRL reads 0x01.
- W1C on MATCH issued in the same cycle as a new match event -> MATCH remains 1. Read at addr NUM_CH*0x10 -> rdata = 0; a write there has no effect on any channel.
- With TIMER_PRESCALER_EN: CTRL = 0x0201 (PSC = 2) -> COUNT increments every 3 cycles. Without the macro: PSC reads 0 and COUNT increments every cycle.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Brief    : Register map, CTRL/STATUS bit positions and mode encodings shared
//            by the multi-channel timer (optional feature: TIMER_PRESCALER_EN).
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

  // Word offsets inside one channel window (byte offset >> 2)
  localparam logic [1:0] c_reg_ctrl    = 2'd0;
  localparam logic [1:0] c_reg_count   = 2'd1;
  localparam logic [1:0] c_reg_compare = 2'd2;
  localparam logic [1:0] c_reg_status  = 2'd3;

  localparam int c_ctrl_en       = 0;
  localparam int c_ctrl_clr      = 1;
  localparam int c_ctrl_mode     = 2;
  localparam int c_ctrl_ovf_ie   = 3;
  localparam int c_ctrl_match_ie = 4;
  localparam int c_ctrl_psc_lsb  = 8;
  localparam int c_psc_width     = 8;

  localparam int c_stat_ovf   = 0;
  localparam int c_stat_match = 1;

  localparam logic c_mode_free_run    = 1'b0;
  localparam logic c_mode_auto_reload = 1'b1;

  localparam int c_ch_stride = 'h10;
  localparam int c_ch_shift  = $clog2(c_ch_stride);

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
// Module   : timer_channel
// Brief    : One timer channel: CTRL/COUNT/COMPARE/STATUS, tick generation and
//            optional prescaler (TIMER_PRESCALER_EN).
// Revision : 1.0 - initial release
// ============================================================================
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_WIDTH  = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_ctrl_we,
  input  logic                  i_cmp_we,
  input  logic                  i_stat_we,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [1:0]            i_reg_sel,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_ovf,
  output logic                  o_irq
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  logic                   r_en;
  logic                   r_mode;
  logic                   r_ovf_ie;
  logic                   r_match_ie;
  logic                   r_ovf;
  logic                   r_match;
  logic [CNT_WIDTH-1:0]   r_count;
  logic [CNT_WIDTH-1:0]   r_compare;
  logic                   w_tick;
  logic                   w_clr;
  logic                   w_at_max;
  logic                   w_at_cmp;
  logic                   w_set_ovf;
  logic                   w_set_match;
  logic [c_psc_width-1:0] w_psc_rd;
  logic                   w_unused_wdata;

  assign w_unused_wdata = &{1'b0, i_wdata};

`ifdef TIMER_PRESCALER_EN
  logic [c_psc_width-1:0] r_psc;
  logic [c_psc_width-1:0] r_psc_cnt;

  // Any CTRL write rewrites PSC and therefore restarts the divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc     <= '0;
      r_psc_cnt <= '0;
    end else begin
      if (i_ctrl_we) begin
        r_psc <= i_wdata[c_ctrl_psc_lsb +: c_psc_width];
      end
      if (!r_en || i_ctrl_we || r_psc_cnt == r_psc) begin
        r_psc_cnt <= '0;
      end else begin
        r_psc_cnt <= r_psc_cnt + c_psc_width'(1);
      end
    end
  end

  assign w_tick   = r_en && (r_psc_cnt == r_psc);
  assign w_psc_rd = r_psc;
`else
  assign w_tick   = r_en;
  assign w_psc_rd = '0;
`endif

  assign w_clr       = i_ctrl_we & i_wdata[c_ctrl_clr];
  assign w_at_max    = (r_count == c_cnt_max);
  assign w_at_cmp    = (r_count == r_compare);
  // A tick swallowed by CLR raises no flag
  assign w_set_ovf   = w_tick & ~w_clr & w_at_max;
  assign w_set_match = w_tick & ~w_clr & w_at_cmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en       <= 1'b0;
      r_mode     <= c_mode_free_run;
      r_ovf_ie   <= 1'b0;
      r_match_ie <= 1'b0;
      r_compare  <= '0;
    end else begin
      if (i_ctrl_we) begin
        r_en       <= i_wdata[c_ctrl_en];
        r_mode     <= i_wdata[c_ctrl_mode];
        r_ovf_ie   <= i_wdata[c_ctrl_ovf_ie];
        r_match_ie <= i_wdata[c_ctrl_match_ie];
      end
      if (i_cmp_we) begin
        r_compare <= i_wdata[CNT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_clr) begin
      r_count <= '0;
    end else if (w_tick) begin
      if (r_mode == c_mode_auto_reload && w_at_cmp) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + c_cnt_one;
      end
    end
  end

  // Hardware set takes priority over a same-cycle write-one-to-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf   <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_ovf   <= w_set_ovf   | (r_ovf   & ~(i_stat_we & i_wdata[c_stat_ovf]));
      r_match <= w_set_match | (r_match & ~(i_stat_we & i_wdata[c_stat_match]));
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_reg_sel)
      c_reg_ctrl: begin
        o_rdata[c_ctrl_en]                       = r_en;
        o_rdata[c_ctrl_mode]                     = r_mode;
        o_rdata[c_ctrl_ovf_ie]                   = r_ovf_ie;
        o_rdata[c_ctrl_match_ie]                 = r_match_ie;
        o_rdata[c_ctrl_psc_lsb +: c_psc_width]   = w_psc_rd;
      end
      c_reg_count:   o_rdata = DATA_WIDTH'(r_count);
      c_reg_compare: o_rdata = DATA_WIDTH'(r_compare);
      c_reg_status: begin
        o_rdata[c_stat_ovf]   = r_ovf;
        o_rdata[c_stat_match] = r_match;
      end
      default: o_rdata = '0;
    endcase
  end

  assign o_ovf = r_ovf;
  assign o_irq = (r_ovf & r_ovf_ie) | (r_match & r_match_ie);

endmodule : timer_channel
`default_nettype wire

// File: rtl/timer_multi_ch.sv
`default_nettype none
// ============================================================================
// Module   : timer_multi_ch
// Brief    : Memory-mapped NUM_CH-channel up-counter/timer with registered
//            read port (optional prescaler via TIMER_PRESCALER_EN).
// Revision : 1.0 - initial release
// ============================================================================
module timer_multi_ch
  import timer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [NUM_CH-1:0]     overflow,
  output logic [NUM_CH-1:0]     irq
);

  localparam int c_ch_bits = ADDR_WIDTH - c_ch_shift;

  logic [c_ch_bits-1:0]  w_ch;
  logic [1:0]            w_reg;
  logic [NUM_CH-1:0]     w_hit;
  logic [DATA_WIDTH-1:0] w_ch_rdata [NUM_CH];
  logic [DATA_WIDTH-1:0] w_rd_mux;
  logic                  w_unused_addr;

  assign w_ch          = addr[ADDR_WIDTH-1:c_ch_shift];
  assign w_reg         = addr[3:2];
  assign w_unused_addr = &{1'b0, addr[1:0]};

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign w_hit[i] = (w_ch == c_ch_bits'(i));

      timer_channel #(
        .CNT_WIDTH  (CNT_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_ctrl_we (wr_en & w_hit[i] & (w_reg == c_reg_ctrl)),
        .i_cmp_we  (wr_en & w_hit[i] & (w_reg == c_reg_compare)),
        .i_stat_we (wr_en & w_hit[i] & (w_reg == c_reg_status)),
        .i_wdata   (wdata),
        .i_reg_sel (w_reg),
        .o_rdata   (w_ch_rdata[i]),
        .o_ovf     (overflow[i]),
        .o_irq     (irq[i])
      );
    end
  endgenerate

  // No hit means an unmapped channel, which reads as zero
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_hit[i]) begin
        w_rd_mux = w_ch_rdata[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= w_rd_mux;
    end
  end

endmodule : timer_multi_ch
`default_nettype wire
